chrono_counter: RTL and testbench

//  Parametrised stopwatch/timer core: counts HH:MM:SS up or down from a divided system clock.

---
 rtl/chrono_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/chrono_counter.sv | 172 +++++++++++++++++
 tb/tb_chrono_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared types and limits for the chrono_counter stopwatch/timer core.
package chrono_pkg;

  localparam int unsigned FIELD_W = 8;

  typedef logic [FIELD_W-1:0] field_t;

  localparam field_t SEC_MAX = 8'd59;
  localparam field_t MIN_MAX = 8'd59;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_e;

  function automatic field_t sat(input field_t v, input field_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick per counted second; holds phase while disabled.
module tick_prescaler #(
  parameter int unsigned CLK_PER_SEC = 25_000_000,
  parameter int unsigned PRESC_W     = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_PER_SEC - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Combinational so the time fields step on the same edge the count wraps.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chrono_counter.sv
// Stopwatch/timer core: HH:MM:SS up/down counting with preset load, lap capture and done pulse.
module chrono_counter
  import chrono_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 25_000_000,
  parameter int unsigned HOUR_MAX    = 99,
  parameter int unsigned PRESC_W     = 25
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_stop,
  input  logic         lap,
  input  logic         count_down,
  input  logic         load,
  input  logic [7:0]   load_h,
  input  logic [7:0]   load_m,
  input  logic [7:0]   load_s,
  output logic [7:0]   hours,
  output logic [7:0]   minutes,
  output logic [7:0]   seconds,
  output logic [7:0]   lap_h,
  output logic [7:0]   lap_m,
  output logic [7:0]   lap_s,
  output logic         lap_valid,
  output logic         running,
  output logic         sec_tick,
  output logic         done
);

  localparam field_t HMAX = field_t'(HOUR_MAX);

  run_e   run_q, run_d;
  mode_e  mode_q, mode_d;
  logic   ss_prev_q, lap_prev_q;
  field_t h_q, h_d, m_q, m_d, s_q, s_d;
  field_t lh_q, lh_d, lm_q, lm_d, ls_q, ls_d;
  logic   lapv_q, lapv_d;
  logic   tick_q, done_q, done_d;

  logic   tick, clr;
  logic   ss_edge, lap_edge, load_eff, time_zero;

  tick_prescaler #(
    .CLK_PER_SEC (CLK_PER_SEC),
    .PRESC_W     (PRESC_W)
  ) u_presc (
    .clock (clock),
    .reset (reset),
    .en    (run_q == RUNNING),
    .clr   (clr),
    .tick  (tick)
  );

  assign ss_edge   = start_stop & ~ss_prev_q;
  assign lap_edge  = lap & ~lap_prev_q;
  assign load_eff  = load && (run_q == STOPPED);
  assign time_zero = (h_q == '0) && (m_q == '0) && (s_q == '0);

  always_comb begin
    run_d  = run_q;
    mode_d = mode_q;
    h_d    = h_q;
    m_d    = m_q;
    s_d    = s_q;
    lh_d   = lh_q;
    lm_d   = lm_q;
    ls_d   = ls_q;
    lapv_d = lapv_q;
    done_d = 1'b0;
    clr    = 1'b0;

    if (tick) begin
      if (mode_q == MODE_UP) begin
        if (s_q < SEC_MAX) s_d = s_q + 8'd1;
        else begin
          s_d = '0;
          if (m_q < MIN_MAX) m_d = m_q + 8'd1;
          else begin
            m_d = '0;
            if (h_q < HMAX) h_d = h_q + 8'd1;
            else begin
              h_d    = '0;
              done_d = 1'b1;
            end
          end
        end
      end else begin
        if (s_q != '0) s_d = s_q - 8'd1;
        else begin
          s_d = SEC_MAX;
          if (m_q != '0) m_d = m_q - 8'd1;
          else begin
            m_d = MIN_MAX;
            h_d = (h_q != '0) ? h_q - 8'd1 : HMAX;
          end
        end
        if ((h_d == '0) && (m_d == '0) && (s_d == '0)) begin
          done_d = 1'b1;
          run_d  = STOPPED;
          clr    = 1'b1;
        end
      end
    end

    // Load only acts while stopped, so it never collides with a tick; it masks the button edges.
    if (load_eff) begin
      h_d    = sat(load_h, HMAX);
      m_d    = sat(load_m, MIN_MAX);
      s_d    = sat(load_s, SEC_MAX);
      lapv_d = 1'b0;
      clr    = 1'b1;
    end else begin
      if (ss_edge) begin
        if (run_q == RUNNING) run_d = STOPPED;
        else if (!(count_down && time_zero)) begin
          run_d  = RUNNING;
          mode_d = count_down ? MODE_DOWN : MODE_UP;
        end
      end
      if (lap_edge) begin
        lh_d   = h_q;
        lm_d   = m_q;
        ls_d   = s_q;
        lapv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q      <= STOPPED;
      mode_q     <= MODE_UP;
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      h_q        <= '0;
      m_q        <= '0;
      s_q        <= '0;
      lh_q       <= '0;
      lm_q       <= '0;
      ls_q       <= '0;
      lapv_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      run_q      <= run_d;
      mode_q     <= mode_d;
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
      h_q        <= h_d;
      m_q        <= m_d;
      s_q        <= s_d;
      lh_q       <= lh_d;
      lm_q       <= lm_d;
      ls_q       <= ls_d;
      lapv_q     <= lapv_d;
      tick_q     <= tick;
      done_q     <= done_d;
    end
  end

  assign hours     = h_q;
  assign minutes   = m_q;
  assign seconds   = s_q;
  assign lap_h     = lh_q;
  assign lap_m     = lm_q;
  assign lap_s     = ls_q;
  assign lap_valid = lapv_q;
  assign running   = (run_q == RUNNING);
  assign sec_tick  = tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_chrono_counter.sv
// Bench for chrono_counter: total-seconds reference model checked every cycle, plus directed literals.
module tb_chrono_counter;

  localparam int CPS    = 4;
  localparam int HMAX   = 99;
  localparam int PERIOD = (HMAX + 1) * 3600;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0, lap = 1'b0, count_down = 1'b0, load = 1'b0;
  logic [7:0] load_h = '0, load_m = '0, load_s = '0;
  logic [7:0] hours, minutes, seconds, lap_h, lap_m, lap_s;
  logic       lap_valid, running, sec_tick, done;

  chrono_counter #(
    .CLK_PER_SEC (CPS),
    .HOUR_MAX    (HMAX),
    .PRESC_W     (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .count_down (count_down),
    .load       (load),
    .load_h     (load_h),
    .load_m     (load_m),
    .load_s     (load_s),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .lap_h      (lap_h),
    .lap_m      (lap_m),
    .lap_s      (lap_s),
    .lap_valid  (lap_valid),
    .running    (running),
    .sec_tick   (sec_tick),
    .done       (done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time kept as total seconds, phase as a plain cycle count.
  int  m_total, m_phase, m_lap;
  bit  m_run, m_down, m_lapv, m_tick, m_done, m_prev_ss, m_prev_lap;
  bit  m_valid = 1'b0;
  int  old_total;
  bit  old_run, e_ss, e_lap, tk;

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clock) begin
    m_valid = 1'b1;
    if (!reset) begin
      m_total = 0; m_phase = 0; m_lap = 0; m_run = 0; m_down = 0;
      m_lapv = 0; m_tick = 0; m_done = 0; m_prev_ss = 1; m_prev_lap = 1;
    end else begin
      old_total = m_total;
      old_run   = m_run;
      e_ss  = start_stop && !m_prev_ss;
      e_lap = lap && !m_prev_lap;
      tk    = m_run && (m_phase == CPS - 1);
      m_tick = tk;
      m_done = 0;
      if (m_run) m_phase = tk ? 0 : m_phase + 1;
      if (tk) begin
        if (!m_down) begin
          m_total = (m_total + 1) % PERIOD;
          if (m_total == 0) m_done = 1;
        end else begin
          m_total = m_total - 1;
          if (m_total == 0) begin m_done = 1; m_run = 0; m_phase = 0; end
        end
      end
      if (load && !old_run) begin
        m_total = clampi(int'(load_h), HMAX) * 3600 + clampi(int'(load_m), 59) * 60
                + clampi(int'(load_s), 59);
        m_phase = 0;
        m_lapv  = 0;
      end else begin
        if (e_ss) begin
          if (old_run) m_run = 0;
          else if (!(count_down && old_total == 0)) begin m_run = 1; m_down = count_down; end
        end
        if (e_lap) begin m_lap = old_total; m_lapv = 1; end
      end
      m_prev_ss  = start_stop;
      m_prev_lap = lap;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("hours",     32'(hours),     32'(m_total / 3600));
      chk("minutes",   32'(minutes),   32'((m_total / 60) % 60));
      chk("seconds",   32'(seconds),   32'(m_total % 60));
      chk("lap_h",     32'(lap_h),     32'(m_lap / 3600));
      chk("lap_m",     32'(lap_m),     32'((m_lap / 60) % 60));
      chk("lap_s",     32'(lap_s),     32'(m_lap % 60));
      chk("lap_valid", 32'(lap_valid), 32'(m_lapv));
      chk("running",   32'(running),   32'(m_run));
      chk("sec_tick",  32'(sec_tick),  32'(m_tick));
      chk("done",      32'(done),      32'(m_done));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_h = 8'(h); load_m = 8'(m); load_s = 8'(s);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    // 1: button held through reset never toggles
    reset = 1'b0; start_stop = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    chk("t1_running", 32'(running), 32'd0);
    chk("t1_seconds", 32'(seconds), 32'd0);
    chk("t1_lapv",    32'(lap_valid), 32'd0);
    start_stop = 1'b0;
    cyc(1);

    // 2: up count, stop freezes, resume keeps prescaler phase
    count_down = 1'b0;
    press();
    cyc(8);
    chk("t2_seconds", 32'(seconds), 32'd2);
    chk("t2_tick",    32'(sec_tick), 32'd1);
    press();
    cyc(10);
    chk("t2_frozen",  32'(seconds), 32'd2);
    chk("t2_stopped", 32'(running), 32'd0);
    press();
    cyc(3);
    chk("t2_resume",  32'(seconds), 32'd3);
    press();

    // 3: up wrap from HOUR_MAX:59:59
    do_load(99, 59, 59);
    press();
    cyc(3);
    chk("t3_pre_h",  32'(hours), 32'd99);
    cyc(1);
    chk("t3_h",      32'(hours), 32'd0);
    chk("t3_s",      32'(seconds), 32'd0);
    chk("t3_done",   32'(done), 32'd1);
    chk("t3_run",    32'(running), 32'd1);
    press();

    // 4: count down to zero, then start rejected
    do_load(0, 1, 0);
    count_down = 1'b1;
    press();
    cyc(4);
    chk("t4_s59",    32'(seconds), 32'd59);
    chk("t4_m0",     32'(minutes), 32'd0);
    cyc(236);
    chk("t4_zero",   32'(seconds), 32'd0);
    chk("t4_done",   32'(done), 32'd1);
    chk("t4_run",    32'(running), 32'd0);
    press();
    cyc(1);
    chk("t4_reject", 32'(running), 32'd0);
    count_down = 1'b0;

    // 5: lap edge coincident with tick captures pre-increment time
    do_load(0, 0, 5);
    press();
    cyc(3);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("t5_lap_s",  32'(lap_s), 32'd5);
    chk("t5_sec",    32'(seconds), 32'd6);
    chk("t5_lapv",   32'(lap_valid), 32'd1);
    press();

    // 6: saturating load, load ignored while running, reset mid-count
    do_load(200, 75, 80);
    chk("t6_h",      32'(hours), 32'd99);
    chk("t6_m",      32'(minutes), 32'd59);
    chk("t6_s",      32'(seconds), 32'd59);
    chk("t6_lapv",   32'(lap_valid), 32'd0);
    press();
    do_load(1, 2, 3);
    chk("t6_ign_h",  32'(hours), 32'd99);
    chk("t6_ign_s",  32'(seconds), 32'd59);
    chk("t6_ign_run", 32'(running), 32'd1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("t6_rst_h",  32'(hours), 32'd0);
    chk("t6_rst_s",  32'(seconds), 32'd0);
    chk("t6_rst_run", 32'(running), 32'd0);
    chk("t6_rst_lap", 32'(lap_h), 32'd0);

    // Randomised traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 14) == 0) lap = ~lap;
      if ($urandom_range(0, 29) == 0) count_down = ~count_down;
      load  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 599) != 0);
      case ($urandom_range(0, 3))
        0: begin load_h = 8'($urandom_range(0, 255)); load_m = 8'($urandom_range(0, 255));
                 load_s = 8'($urandom_range(0, 255)); end
        1: begin load_h = 8'd99; load_m = 8'd59; load_s = 8'($urandom_range(50, 70)); end
        default: begin load_h = 8'd0; load_m = 8'($urandom_range(0, 1));
                       load_s = 8'($urandom_range(0, 6)); end
      endcase
      cyc(1);
    end
    reset = 1'b1;
    load  = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
